// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for one shared ALU
// One operation in flight; MUL holds EXEC for two cycles before the result is registered.
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req0_op,
  input  logic [3:0]   req1_op,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_zero,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_y,
  input  logic         alu_zero,
  output logic         busy
);

  localparam logic [3:0] OP_MUL = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t       r_state, w_next;
  logic [N-1:0] r_a, r_b, r_rsp_data;
  logic [3:0]   r_op;
  logic         r_grant, r_last_grant, r_cnt, r_rsp_zero;
  logic         w_accept, w_sel, w_exec_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_sel       = 1'b0;
    w_exec_done = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the requester that did not win last time is served.
        if (req0_valid && req1_valid) w_sel = ~r_last_grant;
        else                          w_sel = req1_valid;
        if (req0_valid || req1_valid) begin
          w_accept   = 1'b1;
          req0_ready = ~w_sel;
          req1_ready = w_sel;
          w_next     = S_EXEC;
        end
      end
      S_EXEC: begin
        w_exec_done = (r_op != OP_MUL) || r_cnt;
        if (w_exec_done) w_next = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = ~r_grant;
        rsp1_valid = r_grant;
        if (r_grant ? rsp1_ready : rsp0_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a          <= w_sel ? req1_a  : req0_a;
        r_b          <= w_sel ? req1_b  : req0_b;
        r_op         <= w_sel ? req1_op : req0_op;
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
        r_cnt        <= 1'b0;
      end
      if (r_state == S_EXEC) begin
        if (w_exec_done) begin
          r_rsp_data <= alu_y;
          r_rsp_zero <= alu_zero;
        end else begin
          r_cnt <= 1'b1;
        end
      end
    end
  end

  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_op   = r_op;
  assign rsp_data = r_rsp_data;
  assign rsp_zero = r_rsp_zero;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed bench for alu_arbiter with a small ALU model
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_arbiter;

  localparam int N = 32;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b1110;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [N-1:0] rsp_data, alu_a, alu_b, alu_y;
  logic         rsp_zero, alu_zero, busy;
  logic [3:0]   alu_op;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      OP_AND:  alu_y = alu_a & alu_b;
      OP_OR:   alu_y = alu_a | alu_b;
      OP_ADD:  alu_y = alu_a + alu_b;
      OP_SUB:  alu_y = alu_a - alu_b;
      OP_MUL:  alu_y = alu_a * alu_b;
      default: alu_y = '0;
    endcase
  end
  assign alu_zero = (alu_y == '0);

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_zero(alu_zero), .busy(busy)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
    {req0_a, req0_b, req1_a, req1_b} = '0;
    req0_op = '0;
    req1_op = '0;
    @(negedge clk);
    step();
    chk("rst_busy", busy, 0);
    chk("rst_readies", {req0_ready, req1_ready}, 0);
    chk("rst_rsp_valids", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    step();
    chk("idle_no_req_busy", busy, 0);

    // single request: ADD 5+7
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = OP_ADD;
    #1;
    chk("single_req0_ready", req0_ready, 1);
    chk("single_req1_ready", req1_ready, 0);
    step();
    req0_valid = 0;
    chk("single_exec_busy", busy, 1);
    chk("single_exec_no_rsp", rsp0_valid, 0);
    chk("single_alu_a", alu_a, 5);
    chk("single_alu_op", alu_op, OP_ADD);
    step();
    chk("single_rsp0_valid", rsp0_valid, 1);
    chk("single_rsp1_valid", rsp1_valid, 0);
    chk("single_rsp_data", rsp_data, 12);
    chk("single_rsp_zero", rsp_zero, 0);
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    chk("single_back_idle", busy, 0);
    chk("single_rsp0_cleared", rsp0_valid, 0);

    // tie right after reset: req0 first
    do_reset();
    req0_valid = 1; req0_a = 3; req0_b = 3; req0_op = OP_SUB;
    req1_valid = 1; req1_a = 32'h0F; req1_b = 32'hF0; req1_op = OP_OR;
    #1;
    chk("tie_req0_ready", req0_ready, 1);
    chk("tie_req1_ready", req1_ready, 0);
    step();
    req0_valid = 0;
    chk("tie_exec_req1_blocked", req1_ready, 0);
    step();
    chk("tie_rsp0_valid", rsp0_valid, 1);
    chk("tie_rsp0_data", rsp_data, 0);
    chk("tie_rsp0_zero", rsp_zero, 1);
    rsp0_ready = 1;
    #1;
    chk("tie_resp_no_accept", req1_ready, 0);
    step();
    rsp0_ready = 0;
    #1;
    chk("tie_req1_now_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    chk("tie_rsp1_valid", rsp1_valid, 1);
    chk("tie_rsp0_quiet", rsp0_valid, 0);
    chk("tie_rsp1_data", rsp_data, 32'hFF);
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;

    // fairness: both held valid for six operations
    req0_valid = 1; req0_a = 1;  req0_b = 2;  req0_op = OP_ADD;
    req1_valid = 1; req1_a = 10; req1_b = 20; req1_op = OP_ADD;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("fair_grant%0d", i), {req1_ready, req0_ready}, (i % 2) ? 2'b10 : 2'b01);
      step();
      step();
      chk($sformatf("fair_rsp%0d", i), {rsp1_valid, rsp0_valid}, (i % 2) ? 2'b10 : 2'b01);
      chk($sformatf("fair_data%0d", i), rsp_data, (i % 2) ? 30 : 3);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    step();

    // MUL on req1: two EXEC cycles
    req1_valid = 1; req1_a = 6; req1_b = 7; req1_op = OP_MUL;
    #1;
    chk("mul_req1_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    chk("mul_exec1_no_rsp", rsp1_valid, 0);
    step();
    chk("mul_exec2_no_rsp", rsp1_valid, 0);
    chk("mul_exec2_busy", busy, 1);
    step();
    chk("mul_rsp1_valid", rsp1_valid, 1);
    chk("mul_rsp_data", rsp_data, 42);
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;

    // backpressure on rsp0 for five cycles
    req0_valid = 1; req0_a = 100; req0_b = 23; req0_op = OP_ADD;
    step();
    req0_valid = 0;
    step();
    req0_valid = 1; req1_valid = 1; rsp1_ready = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_rsp0_valid%0d", i), rsp0_valid, 1);
      chk($sformatf("bp_data%0d", i), rsp_data, 123);
      chk($sformatf("bp_readies%0d", i), {req0_ready, req1_ready}, 0);
      chk($sformatf("bp_busy%0d", i), busy, 1);
      step();
    end
    req0_valid = 0; req1_valid = 0; rsp1_ready = 0;
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    chk("bp_released_idle", busy, 0);

    // reset during EXEC aborts and restores req0 priority on the next tie
    req1_valid = 1; req1_a = 1; req1_b = 1; req1_op = OP_ADD;
    step();
    req1_valid = 0;
    chk("abort_in_exec", busy, 1);
    rst_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_alu", {alu_a, alu_b}, 0);
    chk("abort_alu_op", alu_op, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_rsp_flags", {rsp_zero, rsp0_valid, rsp1_valid}, 0);
    step();
    rst_n = 1;
    step();
    step();
    chk("abort_no_rsp", {rsp0_valid, rsp1_valid, busy}, 0);
    req0_valid = 1; req0_op = OP_AND;
    req1_valid = 1; req1_op = OP_OR;
    #1;
    chk("abort_tie_grant", {req1_ready, req0_ready}, 2'b01);
    step();
    req0_valid = 0; req1_valid = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
